// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-low abcdefg encodings and a hex decode helper.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    unique case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to active-low seven-segment decoder.
module hex_to_seg7
  import ssd_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_hex);

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with per-frame snapshot,
// leading-zero blanking, digit mask, decimal points, brightness and dead time.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DIV_WIDTH   = 18,
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp_en,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      lzb,
  input  logic [3:0]                brightness,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_start
);

  localparam int unsigned          IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_WIDTH-1:0] DEAD     = DIV_WIDTH'(DEAD_CYCLES);

  logic [DIV_WIDTH-1:0]    r_cnt;
  logic [IDX_W-1:0]        r_idx;

  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dp_en;
  logic [NUM_DIGITS-1:0]   r_digit_en;
  logic                    r_lzb;
  logic [3:0]              r_brightness;

  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_start;

  logic                    w_snap;
  logic                    w_wrap;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [3:0]              w_cur_hex;
  logic [6:0]              w_cur_seg;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_an_d;
  logic [6:0]              w_seg_d;
  logic                    w_dp_d;

  assign w_snap = (r_cnt == '0) && (r_idx == '0);
  assign w_wrap = &r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_WIDTH'(1);
      if (w_wrap) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // Inputs are only sampled at the start of a frame so a scan never mixes two data sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits     <= '0;
      r_dp_en      <= '0;
      r_digit_en   <= '0;
      r_lzb        <= 1'b0;
      r_brightness <= '0;
    end else if (w_snap) begin
      r_digits     <= digits;
      r_dp_en      <= dp_en;
      r_digit_en   <= digit_en;
      r_lzb        <= lzb;
      r_brightness <= brightness;
    end
  end

  always_comb begin
    logic zero_run;
    w_blank  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (r_digits[4*i +: 4] == 4'h0);
      w_blank[i] = r_lzb && (i > 0) && zero_run;
    end
  end

  assign w_cur_hex = r_digits[4*r_idx +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .i_hex (w_cur_hex),
    .o_seg (w_cur_seg)
  );

  // A blanked digit still lights its anode when its decimal point is requested.
  assign w_lit = (r_cnt >= DEAD)
              && (r_cnt[DIV_WIDTH-1 -: 4] <= r_brightness)
              && r_digit_en[r_idx]
              && (!w_blank[r_idx] || r_dp_en[r_idx]);

  always_comb begin
    w_an_d  = '1;
    w_seg_d = SEG_BLANK;
    w_dp_d  = 1'b1;
    if (w_lit) begin
      w_an_d[r_idx] = 1'b0;
      w_seg_d       = w_blank[r_idx] ? SEG_BLANK : w_cur_seg;
      w_dp_d        = ~r_dp_en[r_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an          <= '1;
      r_seg         <= SEG_BLANK;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_an          <= w_an_d;
      r_seg         <= w_seg_d;
      r_dp          <= w_dp_d;
      r_frame_start <= w_snap;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench: absolute-cycle reference model compared every cycle, plus directed
// literal checks of slot timing, snapshot, blanking, brightness, mask and mid-frame reset.
module tb_ssd_scan_driver;

  localparam int N    = 4;
  localparam int DW   = 6;
  localparam int DEAD = 2;

  localparam logic [6:0] HEX_TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits;
  logic [3:0]  dp_en;
  logic [3:0]  digit_en;
  logic        lzb;
  logic [3:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  ssd_scan_driver #(
    .NUM_DIGITS  (N),
    .DIV_WIDTH   (DW),
    .DEAD_CYCLES (DEAD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits      (digits),
    .dp_en       (dp_en),
    .digit_en    (digit_en),
    .lzb         (lzb),
    .brightness  (brightness),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_cyc is the index of the cycle since reset release; slot position,
  // digit and frame boundaries follow from plain division of that count.
  int unsigned m_cyc = 0;
  logic [15:0] sh_dig = '0;
  logic [3:0]  sh_dp = '0, sh_en = '0, sh_b = '0;
  logic        sh_lzb = 1'b0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1, exp_fs = 1'b0;
  int unsigned mc, mi;
  logic        m_blank, m_lit;
  logic [3:0]  m_d;

  always @(posedge clk) begin
    if (rst) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
      m_cyc = 0; sh_dig = '0; sh_dp = '0; sh_en = '0; sh_b = '0; sh_lzb = 1'b0;
    end else begin
      mc      = m_cyc % 64;
      mi      = (m_cyc / 64) % 4;
      m_d     = sh_dig[4*mi +: 4];
      m_blank = sh_lzb && (mi > 0) && ((sh_dig >> (4*mi)) == 16'h0);
      m_lit   = (mc >= DEAD) && ((mc / 4) <= sh_b) && sh_en[mi] && (!m_blank || sh_dp[mi]);
      exp_an  = m_lit ? ~(4'b0001 << mi) : 4'hF;
      exp_seg = (m_lit && !m_blank) ? HEX_TBL[m_d] : 7'h7F;
      exp_dp  = m_lit ? ~sh_dp[mi] : 1'b1;
      exp_fs  = (m_cyc % 256 == 0);
      if (m_cyc % 256 == 0) begin
        sh_dig = digits; sh_dp = dp_en; sh_en = digit_en; sh_b = brightness; sh_lzb = lzb;
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    check("model_an", 32'(an), 32'(exp_an));
    check("model_seg", 32'(seg), 32'(exp_seg));
    check("model_dp", 32'(dp), 32'(exp_dp));
    check("model_fs", 32'(frame_start), 32'(exp_fs));
  end

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 600);
    check("wait_frame", 32'(frame_start), 32'(1));
  endtask

  task automatic run_frame(output int lo[4], output int dpx);
    wait_frame();
    lo  = '{0, 0, 0, 0};
    dpx = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      for (int d = 0; d < 4; d++) if (an[d] == 1'b0) lo[d]++;
      if (an == 4'b1011 && seg == 7'h7F && dp == 1'b0) dpx++;
    end
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] dpe, input logic [3:0] en,
                        input logic z, input logic [3:0] b);
    digits = d; dp_en = dpe; digit_en = en; lzb = z; brightness = b;
  endtask

  initial begin
    int lo[4];
    int dpx;
    int n;
    set_in(16'h12AF, 4'b0010, 4'hF, 1'b0, 4'd15);
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'(4'hF));
    check("rst_seg", 32'(seg), 32'(7'h7F));
    check("rst_dp", 32'(dp), 32'(1));
    check("rst_fs", 32'(frame_start), 32'(0));
    rst = 1'b0;

    @(negedge clk);
    check("fs_first", 32'(frame_start), 32'(1));
    check("an_e1", 32'(an), 32'(4'hF));
    @(negedge clk);
    check("fs_once", 32'(frame_start), 32'(0));
    check("an_e2", 32'(an), 32'(4'hF));
    @(negedge clk);
    check("an_e3", 32'(an), 32'(4'b1110));
    check("seg_F", 32'(seg), 32'(7'b0111000));
    check("dp_d0", 32'(dp), 32'(1));
    n = 1;
    repeat (63) begin
      @(negedge clk);
      if (an == 4'b1110) n++;
    end
    check("lit_d0_62", 32'(n), 32'(62));
    check("dead_an", 32'(an), 32'(4'hF));
    @(negedge clk);
    check("an_d1", 32'(an), 32'(4'b1101));
    check("seg_A", 32'(seg), 32'(7'b0001000));
    check("dp_d1", 32'(dp), 32'(0));

    digits = 16'h0000;
    repeat (64) @(negedge clk);
    check("snap_an_d2", 32'(an), 32'(4'b1011));
    check("snap_seg_2", 32'(seg), 32'(7'b0010010));
    repeat (64) @(negedge clk);
    check("snap_an_d3", 32'(an), 32'(4'b0111));
    check("snap_seg_1", 32'(seg), 32'(7'b1001111));
    wait_frame();
    repeat (2) @(negedge clk);
    check("new_an_d0", 32'(an), 32'(4'b1110));
    check("new_seg_0", 32'(seg), 32'(7'b0000001));

    set_in(16'h0005, 4'b0000, 4'hF, 1'b1, 4'd15);
    run_frame(lo, dpx);
    check("lzb_d0", 32'(lo[0]), 32'(62));
    check("lzb_d1", 32'(lo[1]), 32'(0));
    check("lzb_d2", 32'(lo[2]), 32'(0));
    check("lzb_d3", 32'(lo[3]), 32'(0));

    set_in(16'h0005, 4'b0000, 4'hF, 1'b0, 4'd15);
    run_frame(lo, dpx);
    for (int d = 0; d < 4; d++) check("nolzb_lit", 32'(lo[d]), 32'(62));

    set_in(16'h0005, 4'b0100, 4'hF, 1'b1, 4'd15);
    run_frame(lo, dpx);
    check("lzbdp_d2", 32'(lo[2]), 32'(62));
    check("lzbdp_d3", 32'(lo[3]), 32'(0));
    check("lzbdp_dponly", 32'(dpx), 32'(62));

    set_in(16'h12AF, 4'b0000, 4'hF, 1'b0, 4'd0);
    run_frame(lo, dpx);
    for (int d = 0; d < 4; d++) check("bright0", 32'(lo[d]), 32'(2));

    set_in(16'h12AF, 4'b0000, 4'hF, 1'b0, 4'd7);
    run_frame(lo, dpx);
    for (int d = 0; d < 4; d++) check("bright7", 32'(lo[d]), 32'(30));

    set_in(16'h12AF, 4'b0000, 4'b1011, 1'b0, 4'd15);
    run_frame(lo, dpx);
    check("mask_d2", 32'(lo[2]), 32'(0));
    check("mask_d3", 32'(lo[3]), 32'(62));

    set_in(16'h12AF, 4'b0000, 4'hF, 1'b0, 4'd15);
    n = 0;
    while (((m_cyc / 64) % 4) != 2 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx2", 32'((m_cyc / 64) % 4), 32'(2));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_an", 32'(an), 32'(4'hF));
    check("mrst_seg", 32'(seg), 32'(7'h7F));
    check("mrst_dp", 32'(dp), 32'(1));
    check("mrst_fs", 32'(frame_start), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check("mrst_fs1", 32'(frame_start), 32'(1));
    check("mrst_an1", 32'(an), 32'(4'hF));
    @(negedge clk);
    check("mrst_an2", 32'(an), 32'(4'hF));
    @(negedge clk);
    check("mrst_an3", 32'(an), 32'(4'b1110));

    repeat (40) begin
      repeat ($urandom_range(1, 400)) @(negedge clk);
      digits     = 16'($urandom);
      dp_en      = 4'($urandom);
      digit_en   = 4'($urandom);
      lzb        = 1'($urandom);
      brightness = 4'($urandom);
      if ($urandom_range(0, 1) == 1) digits = digits >> (4 * $urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (300) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
